// File: rtl/alu_inst_fifo.sv
// Instruction/result FIFO in front of the ALU execute stage: push din, pop to registered dout.
// Latency: popped word and rd_ack are registered, 1 cycle after rd_en; pushed words are poppable next cycle.
// Backpressure: pushes while full raise wr_err, pops while empty raise rd_err; neither disturbs stored state.
module alu_inst_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic                  wr_ack,
    output logic                  wr_err,
    output logic                  rd_ack,
    output logic                  rd_err,
    output logic [ADDR_WIDTH:0]   data_count
);

    localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   ONE_CNT  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ONE_PTR  = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] head_q, head_d;
    logic [ADDR_WIDTH-1:0] tail_q, tail_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  wr_ack_q, wr_err_q, rd_ack_q, rd_err_q;
    logic                  push_ok, pop_ok;

    // Flags come from the registered count only, so accept/reject decisions see pre-edge occupancy.
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    assign push_ok = wr_en & ~full;
    assign pop_ok  = rd_en & ~empty;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_ok) tail_d = tail_q + ONE_PTR;
        if (pop_ok)  head_d = head_q + ONE_PTR;
        if (push_ok && !pop_ok)      count_d = count_q + ONE_CNT;
        else if (pop_ok && !push_ok) count_d = count_q - ONE_CNT;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            wr_ack_q <= 1'b0;
            wr_err_q <= 1'b0;
            rd_ack_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            wr_ack_q <= push_ok;
            wr_err_q <= wr_en & full;
            rd_ack_q <= pop_ok;
            rd_err_q <= rd_en & empty;
            if (pop_ok) dout_q <= mem_q[head_q];
        end
    end

    // Storage is deliberately not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[tail_q] <= din;
    end

    assign dout       = dout_q;
    assign wr_ack     = wr_ack_q;
    assign wr_err     = wr_err_q;
    assign rd_ack     = rd_ack_q;
    assign rd_err     = rd_err_q;
    assign data_count = count_q;

endmodule

// File: tb/tb_alu_inst_fifo.sv
// Directed checks for alu_inst_fifo: reset, fill/drain, overflow, underflow, simultaneous ops, wrap, async reset.
module tb_alu_inst_fifo;

    logic        clk;
    logic        reset_n;
    logic        wr_en;
    logic [31:0] din;
    logic        rd_en;
    logic [31:0] dout;
    logic        full, empty;
    logic        wr_ack, wr_err, rd_ack, rd_err;
    logic [3:0]  data_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mq[$];
    logic [31:0] d, e;
    logic        w, r, exp_push, exp_pop;

    alu_inst_fifo #(.DATA_WIDTH(32), .DEPTH(8), .ADDR_WIDTH(3)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .din        (din),
        .rd_en      (rd_en),
        .dout       (dout),
        .full       (full),
        .empty      (empty),
        .wr_ack     (wr_ack),
        .wr_err     (wr_err),
        .rd_ack     (rd_ack),
        .rd_err     (rd_err),
        .data_count (data_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of requests, then sample 1 time unit after the edge.
    task automatic cyc(input logic wi, input logic [31:0] di, input logic ri);
        wr_en = wi;
        din   = di;
        rd_en = ri;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        din     = '0;
        #12;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(data_count), 32'd0);
        chk("rst_dout", dout, 32'd0);
        chk("rst_strobes", {28'd0, wr_ack, wr_err, rd_ack, rd_err}, 32'd0);
        reset_n = 1'b1;

        // Fill
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 32'(i), 1'b0);
            chk("fill_wrack", 32'(wr_ack), 32'd1);
            chk("fill_count", 32'(data_count), 32'(i));
        end
        chk("fill_full", 32'(full), 32'd1);

        // Overflow
        cyc(1'b1, 32'hDEAD, 1'b0);
        chk("ovf_wrerr", 32'(wr_err), 32'd1);
        chk("ovf_wrack", 32'(wr_ack), 32'd0);
        chk("ovf_count", 32'(data_count), 32'd8);
        cyc(1'b0, 32'd0, 1'b0);
        chk("ovf_wrerr_clr", 32'(wr_err), 32'd0);

        // Drain
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b0, 32'd0, 1'b1);
            chk("drain_rdack", 32'(rd_ack), 32'd1);
            chk("drain_dout", dout, 32'(i));
            chk("drain_count", 32'(data_count), 32'(8 - i));
        end
        chk("drain_empty", 32'(empty), 32'd1);

        // Underflow, rd_en held three cycles
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 32'd0, 1'b1);
            chk("udf_rderr", 32'(rd_err), 32'd1);
            chk("udf_rdack", 32'(rd_ack), 32'd0);
            chk("udf_dout", dout, 32'd8);
        end
        cyc(1'b0, 32'd0, 1'b0);
        chk("udf_rderr_clr", 32'(rd_err), 32'd0);

        // Simultaneous on empty: push wins, pop rejected, no bypass
        cyc(1'b1, 32'h11, 1'b1);
        chk("sim_e_rderr", 32'(rd_err), 32'd1);
        chk("sim_e_wrack", 32'(wr_ack), 32'd1);
        chk("sim_e_count", 32'(data_count), 32'd1);
        chk("sim_e_dout", dout, 32'd8);
        cyc(1'b1, 32'h12, 1'b0);
        cyc(1'b1, 32'h13, 1'b0);
        cyc(1'b1, 32'h14, 1'b0);
        chk("sim_m_pre", 32'(data_count), 32'd4);

        // Simultaneous mid-occupancy
        cyc(1'b1, 32'h15, 1'b1);
        chk("sim_m_count", 32'(data_count), 32'd4);
        chk("sim_m_dout", dout, 32'h11);
        chk("sim_m_acks", {30'd0, wr_ack, rd_ack}, 32'd3);
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h16 + 32'(i), 1'b0);
        chk("sim_f_pre", 32'(full), 32'd1);

        // Simultaneous on full: pop wins, push rejected
        cyc(1'b1, 32'h20, 1'b1);
        chk("sim_f_wrerr", 32'(wr_err), 32'd1);
        chk("sim_f_rdack", 32'(rd_ack), 32'd1);
        chk("sim_f_count", 32'(data_count), 32'd7);
        chk("sim_f_dout", dout, 32'h12);
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, 32'd0, 1'b1);
            chk("sim_drain_dout", dout, 32'h13 + 32'(i));
        end
        chk("sim_drain_empty", 32'(empty), 32'd1);

        // Interleaved traffic across pointer wrap, checked against a queue model
        mq.delete();
        for (int k = 0; k < 20; k++) begin
            w = 1'b1;
            r = ((k % 4) != 0);
            d = 32'h100 + 32'(k);
            exp_push = w && (mq.size() < 8);
            exp_pop  = r && (mq.size() > 0);
            cyc(w, d, r);
            if (exp_pop) begin
                e = mq.pop_front();
                chk("wrap_dout", dout, e);
            end
            chk("wrap_rdack", 32'(rd_ack), 32'(exp_pop));
            if (exp_push) mq.push_back(d);
            chk("wrap_count", 32'(data_count), 32'(mq.size()));
        end

        // Asynchronous reset mid-cycle with words still stored
        wr_en = 1'b0;
        rd_en = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_count", 32'(data_count), 32'd0);
        chk("arst_dout", dout, 32'd0);
        chk("arst_strobes", {28'd0, wr_ack, wr_err, rd_ack, rd_err}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        cyc(1'b0, 32'd0, 1'b1);
        chk("arst_discard", 32'(rd_err), 32'd1);
        cyc(1'b1, 32'hAB, 1'b0);
        cyc(1'b0, 32'd0, 1'b1);
        chk("arst_after_dout", dout, 32'hAB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
